pc_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the branch unit.
- Owns the architectural PC and RA registers and issues instruction-memory reads over a req/ack handshake.
- Presents fetched instructions to decode with valid/ready.
- Consumes the branch unit's next_PC/next_RA results to redirect fetch and update RA, and exports the current RA back to the branch unit.

---
 rtl/bubble_pkg.sv | 32 +++
 rtl/fetch_ctrl_fsm.sv | 59 +++++
 rtl/pc_fetch_unit.sv | 102 ++++++++++
 tb/tb_pc_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bubble_pkg.sv
// Shared fetch/branch definitions: datapath width, fetch FSM states, branch ctrl codes.
package bubble_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BGT  = 3'd2,
    BGTE = 3'd3,
    BLE  = 3'd4,
    BLEQ = 3'd5,
    J    = 3'd6,
    JAL  = 3'd7
  } br_ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_ctrl_fsm.sv
// Fetch sequencing: IDLE/FETCH/HOLD state, stale-request squash and redirect flush.
// Latency: state, squash and flush are registered; strobes are same-cycle decodes.
// Backpressure: stays in HOLD while decode is not ready; FETCH waits on imem_ack.
module fetch_ctrl_fsm
  import bubble_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic imem_ack,
  input  logic id_ready,
  input  logic redirect,
  output logic fetching,
  output logic holding,
  output logic flush,
  output logic capture
`ifdef FETCH_PERF_EN
  ,
  output logic deliver,
  output logic discard
`endif
);

  fetch_state_t state;
  logic         squash;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      squash <= 1'b0;
      flush  <= 1'b0;
    end else begin
      flush <= redirect;
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            squash <= 1'b0;
            if (!squash && !redirect) state <= HOLD;
          end else if (redirect) begin
            // Request already on the bus keeps its address; its data is dropped on ack.
            squash <= 1'b1;
          end
        end
        HOLD: if (redirect || id_ready) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

  assign fetching = (state == FETCH);
  assign holding  = (state == HOLD);
  assign capture  = fetching && imem_ack && !squash && !redirect;

`ifdef FETCH_PERF_EN
  assign deliver = holding && id_ready && !redirect;
  assign discard = (fetching && imem_ack && (squash || redirect)) || (holding && redirect);
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage owning PC/RA; one instruction per two cycles, if_valid one cycle after imem_ack.
// Backpressure: holds the fetched word stable until id_ready; branch redirects override and flush.
// FETCH_PERF_EN adds fetch_count/squash_count counters.
module pc_fetch_unit
  import bubble_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] RESET_RA = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_next_PC,
  input  logic        br_ra_we,
  input  logic [31:0] br_next_RA,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_PC,
  input  logic        id_ready,
  output logic [31:0] fetch_PC,
  output logic [31:0] curr_RA,
  output logic        flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] squash_count
`endif
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic       redirect;
  logic       capture;
  logic [XLEN-1:0] fetch_pc_n;
  fetch_pkt_t pkt;
`ifdef FETCH_PERF_EN
  logic deliver;
  logic discard;
`endif

  assign redirect = br_valid && br_taken;

  fetch_ctrl_fsm u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .imem_ack (imem_ack),
    .id_ready (id_ready),
    .redirect (redirect),
    .fetching (imem_req),
    .holding  (if_valid),
    .flush    (flush),
    .capture  (capture)
`ifdef FETCH_PERF_EN
    ,
    .deliver  (deliver),
    .discard  (discard)
`endif
  );

  always_comb begin
    fetch_pc_n = fetch_PC;
    if (redirect)     fetch_pc_n = word_align(br_next_PC);
    else if (capture) fetch_pc_n = fetch_PC + STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_PC  <= RESET_PC;
      curr_RA   <= RESET_RA;
      imem_addr <= RESET_PC;
      pkt       <= '{pc: RESET_PC, instr: '0};
    end else begin
      fetch_PC <= fetch_pc_n;
      // Address is frozen only while a request is outstanding.
      if (!(imem_req && !imem_ack)) imem_addr <= fetch_pc_n;
      if (capture) pkt <= '{pc: imem_addr, instr: imem_rdata};
      if (br_valid && br_ra_we) curr_RA <= br_next_RA;
    end
  end

  assign if_PC    = pkt.pc;
  assign if_instr = pkt.instr;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      if (deliver) fetch_count  <= fetch_count + 32'd1;
      if (discard) squash_count <= squash_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: delivered instructions checked against an expected-PC queue.
module tb_pc_fetch_unit;

  localparam logic [31:0] RA_INIT = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid, br_taken, br_ra_we;
  logic [31:0] br_next_PC, br_next_RA;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, id_ready, flush;
  logic [31:0] if_instr, if_PC, fetch_PC, curr_RA;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .RESET_RA(RA_INIT), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_valid(br_valid), .br_taken(br_taken), .br_next_PC(br_next_PC),
    .br_ra_we(br_ra_we), .br_next_RA(br_next_RA),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_PC(if_PC), .id_ready(id_ready),
    .fetch_PC(fetch_PC), .curr_RA(curr_RA), .flush(flush)
  );

  // Scoreboard: every accepted instruction must match the oldest expected PC.
  always @(negedge clk) begin
    if (rst_n && if_valid && id_ready && !(br_valid && br_taken)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL deliver_unexpected if_PC=%h if_instr=%h", if_PC, if_instr);
      end else begin
        exp_pc = exp_q.pop_front();
        if (if_PC !== exp_pc || if_instr !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL deliver if_PC=%h if_instr=%h expected PC=%h instr=%h",
                   if_PC, if_instr, exp_pc, mem_word(exp_pc));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_br();
    br_valid = 0; br_taken = 0; br_ra_we = 0; br_next_PC = '0; br_next_RA = '0;
  endtask

  task automatic apply_reset();
    cyc();
    rst_n = 0; imem_ack = 0; id_ready = 0;
    clear_br();
    exp_q.delete();
    cyc();
    cyc();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; imem_ack = 1; id_ready = 1;
    br_valid = 1; br_taken = 1; br_ra_we = 1; br_next_PC = 32'hFFFF_FFF0; br_next_RA = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 || if_instr !== 32'h0 ||
        if_PC !== 32'h0 || fetch_PC !== 32'h0 || curr_RA !== RA_INIT || flush !== 1'b0) begin
      errors++;
      $display("FAIL reset req=%b addr=%h vld=%b instr=%h pc=%h fpc=%h ra=%h flush=%b expected 0/0/0/0/0/0/%h/0",
               imem_req, imem_addr, if_valid, if_instr, if_PC, fetch_PC, curr_RA, flush, RA_INIT);
    end
  endtask

  task automatic test_sequential();
    apply_reset();
    imem_ack = 1; id_ready = 1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 5) id_ready = 0;
      @(negedge clk);
      checks++;
      if (i % 2 == 1) begin
        if (imem_req !== 1'b1 || imem_addr !== 32'(4 * ((i - 1) / 2))) begin
          errors++;
          $display("FAIL seq_req cyc=%0d req=%b addr=%h expected 1 %h", i, imem_req, imem_addr, 4 * ((i - 1) / 2));
        end
      end else begin
        if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_PC !== 32'(4 * (i / 2 - 1))) begin
          errors++;
          $display("FAIL seq_hold cyc=%0d req=%b vld=%b pc=%h expected 0 1 %h", i, imem_req, if_valid, if_PC, 4 * (i / 2 - 1));
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL seq_drain left=%0d expected 0", exp_q.size());
    end
  endtask

  // Continues from test_sequential: instruction at PC 8 sits in HOLD with decode stalled.
  task automatic test_hold_stall();
    exp_q.push_back(32'd8);
    for (int j = 1; j <= 3; j++) begin
      cyc();
      if (j == 3) id_ready = 1;
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_PC !== 32'd8 || if_instr !== mem_word(32'd8) ||
          imem_req !== 1'b0 || fetch_PC !== 32'd12) begin
        errors++;
        $display("FAIL stall cyc=%0d vld=%b pc=%h instr=%h req=%b fpc=%h expected 1 8 %h 0 c",
                 j, if_valid, if_PC, if_instr, imem_req, fetch_PC, mem_word(32'd8));
      end
    end
    cyc();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd12) begin
      errors++;
      $display("FAIL stall_resume req=%b addr=%h expected 1 c", imem_req, imem_addr);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain left=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_pending();
    apply_reset();
    imem_ack = 1; id_ready = 1;
    exp_q.push_back(32'd0);
    cyc();
    cyc(); imem_ack = 0;
    cyc(); br_valid = 1; br_taken = 1; br_next_PC = 32'd40;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd4 || flush !== 1'b0) begin
      errors++;
      $display("FAIL pend_start req=%b addr=%h flush=%b expected 1 4 0", imem_req, imem_addr, flush);
    end
    cyc(); clear_br();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd4 || flush !== 1'b1 || fetch_PC !== 32'd40) begin
      errors++;
      $display("FAIL pend_flush req=%b addr=%h flush=%b fpc=%h expected 1 4 1 28", imem_req, imem_addr, flush, fetch_PC);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'd4 || flush !== 1'b0) begin
      errors++;
      $display("FAIL pend_hold1 addr=%h flush=%b expected 4 0", imem_addr, flush);
    end
    cyc(); imem_ack = 1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd4 || flush !== 1'b0) begin
      errors++;
      $display("FAIL pend_ack req=%b addr=%h flush=%b expected 1 4 0", imem_req, imem_addr, flush);
    end
    cyc(); exp_q.push_back(32'd40);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd40 || if_valid !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL pend_new req=%b addr=%h vld=%b flush=%b expected 1 28 0 0", imem_req, imem_addr, if_valid, flush);
    end
    cyc();
    cyc(); id_ready = 0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pend_drain left=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_hold();
    apply_reset();
    imem_ack = 1; id_ready = 1;
    exp_q.push_back(32'd0);
    cyc(); cyc(); cyc();
    cyc(); br_valid = 1; br_taken = 1; br_next_PC = 32'd24;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_PC !== 32'd4) begin
      errors++;
      $display("FAIL rhold_pre vld=%b pc=%h expected 1 4", if_valid, if_PC);
    end
    cyc(); clear_br(); exp_q.push_back(32'd24);
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd24 || flush !== 1'b1) begin
      errors++;
      $display("FAIL rhold_post vld=%b req=%b addr=%h flush=%b expected 0 1 18 1", if_valid, imem_req, imem_addr, flush);
    end
    cyc();
    cyc(); id_ready = 0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rhold_drain left=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_ra();
    apply_reset();
    imem_ack = 1; id_ready = 1;
    cyc(); br_valid = 1; br_ra_we = 1; br_next_RA = 32'd8; br_taken = 1; br_next_PC = 32'd23;
    @(negedge clk);
    checks++;
    if (curr_RA !== RA_INIT) begin
      errors++;
      $display("FAIL ra_early ra=%h expected %h", curr_RA, RA_INIT);
    end
    cyc(); clear_br(); exp_q.push_back(32'd20);
    @(negedge clk);
    checks++;
    if (curr_RA !== 32'd8 || imem_req !== 1'b1 || imem_addr !== 32'd20 || if_valid !== 1'b0 || flush !== 1'b1) begin
      errors++;
      $display("FAIL ra_jal ra=%h req=%b addr=%h vld=%b flush=%b expected 8 1 14 0 1", curr_RA, imem_req, imem_addr, if_valid, flush);
    end
    cyc(); br_valid = 0; br_ra_we = 1; br_taken = 1; br_next_RA = 32'd99; br_next_PC = 32'd100;
    cyc(); br_valid = 1; br_ra_we = 1; br_taken = 0; br_next_RA = 32'hCAFE_F00D; br_next_PC = 32'd100;
    exp_q.push_back(32'd24);
    @(negedge clk);
    checks++;
    if (curr_RA !== 32'd8 || imem_addr !== 32'd24 || flush !== 1'b0) begin
      errors++;
      $display("FAIL ra_ignored ra=%h addr=%h flush=%b expected 8 18 0", curr_RA, imem_addr, flush);
    end
    cyc(); clear_br();
    @(negedge clk);
    checks++;
    if (curr_RA !== 32'hCAFE_F00D || if_PC !== 32'd24 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL ra_nottaken ra=%h pc=%h vld=%b expected cafef00d 18 1", curr_RA, if_PC, if_valid);
    end
    cyc(); id_ready = 0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ra_drain left=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    imem_ack = 1; id_ready = 1;
    cyc(); br_valid = 1; br_taken = 1; br_next_PC = 32'hFFFF_FFFE;
    exp_q.push_back(32'hFFFF_FFFC);
    cyc(); clear_br();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req req=%b addr=%h expected 1 fffffffc", imem_req, imem_addr);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (fetch_PC !== 32'h0 || if_PC !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_pc fpc=%h pc=%h expected 0 fffffffc", fetch_PC, if_PC);
    end
    cyc(); exp_q.push_back(32'h0);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next req=%b addr=%h expected 1 0", imem_req, imem_addr);
    end
    cyc();
    cyc(); id_ready = 0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_drain left=%0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_pending();
    test_redirect_hold();
    test_ra();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
